// File: rtl/n64_pkg.sv
// rtl/n64_pkg.sv - joybus command constants and scheduler state encoding
package n64_pkg;

  localparam logic [7:0]  CMD_STATUS      = 8'h00;
  localparam logic [7:0]  CMD_POLL        = 8'h01;
  localparam logic [5:0]  RESP_LEN_STATUS = 6'd25;
  localparam logic [5:0]  RESP_LEN_POLL   = 6'd33;
  localparam logic [15:0] N64_DEV_ID      = 16'h0500;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_PROBE      = 3'd1,
    ST_PROBE_WAIT = 3'd2,
    ST_PERIOD     = 3'd3,
    ST_POLL       = 3'd4,
    ST_POLL_WAIT  = 3'd5,
    ST_FAIL       = 3'd6
  } state_t;

endpackage

// File: rtl/n64_tick_timer.sv
// rtl/n64_tick_timer.sv - loadable down-counter with a one-cycle expiry pulse
module n64_tick_timer #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_expired
);

  logic [W-1:0] r_count;

  // Loaded with V on cycle L, the pulse appears on cycle L+V; the counter then parks at zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_expired = (r_count == W'(1));

endmodule

// File: rtl/n64_poll_scheduler.sv
// rtl/n64_poll_scheduler.sv - joybus sequencer: probe, periodic poll, timeout, retry, disconnect
module n64_poll_scheduler
  import n64_pkg::*;
#(
  parameter int TICKS_PER_MICRO = 25,
  parameter int POLL_PERIOD_US  = 1000,
  parameter int TIMEOUT_US      = 200,
  parameter int MAX_RETRY       = 3
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        enable,
  output logic        phy_start,
  output logic [7:0]  phy_cmd,
  output logic [5:0]  phy_rx_len,
  input  logic        phy_busy,
  input  logic        phy_done,
  input  logic [31:0] phy_rx_data,
  output logic [31:0] buttons,
  output logic        buttons_valid,
  output logic        connected,
  output logic [15:0] ctrl_type,
  output logic [7:0]  err_count,
  output logic [2:0]  state_mon
);

  localparam int PERIOD_TICKS  = POLL_PERIOD_US * TICKS_PER_MICRO;
  localparam int TIMEOUT_TICKS = TIMEOUT_US * TICKS_PER_MICRO;
  localparam int CW            = $clog2(PERIOD_TICKS + 1);
  localparam int RW            = $clog2(MAX_RETRY + 1);
  // The period timer is one short because the FSM needs a cycle to re-enter POLL,
  // which keeps consecutive POLL starts exactly PERIOD_TICKS apart.
  localparam logic [CW-1:0] PERIOD_LOAD  = CW'(PERIOD_TICKS - 1);
  localparam logic [CW-1:0] TIMEOUT_LOAD = CW'(TIMEOUT_TICKS);

  if (TIMEOUT_US >= POLL_PERIOD_US) begin : g_bad_timeout
    $error("TIMEOUT_US must be less than POLL_PERIOD_US");
  end

  state_t        r_state, w_next;
  logic [7:0]    r_cmd, w_cmd;
  logic [5:0]    r_len, w_len;
  logic [31:0]   r_buttons;
  logic          r_buttons_valid, r_connected;
  logic [15:0]   r_ctrl_type;
  logic [7:0]    r_err_count;
  logic [RW-1:0] r_retry;

  logic w_start, w_timeout, w_period_exp, w_load_period, w_finish;
  logic w_id_ok, w_retry_max;
  logic w_probe_ok, w_poll_ok, w_err, w_retry_inc, w_disconnect;

  assign w_id_ok     = (phy_rx_data[31:16] == N64_DEV_ID);
  assign w_retry_max = (r_retry >= RW'(MAX_RETRY));
  assign w_finish    = phy_done | w_timeout;

  n64_tick_timer #(.W(CW)) u_timeout (
    .i_clk      (PCLK),
    .i_rst_n    (PRESETn),
    .i_load     (w_start),
    .i_load_val (TIMEOUT_LOAD),
    .o_expired  (w_timeout)
  );

  n64_tick_timer #(.W(CW)) u_period (
    .i_clk      (PCLK),
    .i_rst_n    (PRESETn),
    .i_load     (w_load_period),
    .i_load_val (PERIOD_LOAD),
    .o_expired  (w_period_exp)
  );

  // State register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Next state plus the transaction events consumed by the datapath; done beats a same-cycle timeout.
  always_comb begin
    w_next        = r_state;
    w_start       = 1'b0;
    w_load_period = 1'b0;
    w_probe_ok    = 1'b0;
    w_poll_ok     = 1'b0;
    w_err         = 1'b0;
    w_retry_inc   = 1'b0;
    w_disconnect  = 1'b0;
    case (r_state)
      ST_IDLE: if (enable) w_next = ST_PROBE;
      ST_PROBE: begin
        if (!enable) w_next = ST_IDLE;
        else if (!phy_busy) begin
          w_start = 1'b1;
          w_next  = ST_PROBE_WAIT;
        end
      end
      ST_PROBE_WAIT: begin
        if (w_finish) begin
          if (!enable) w_next = ST_IDLE;
          else if (phy_done && w_id_ok) begin
            w_probe_ok = 1'b1;
            w_next     = ST_POLL;
          end else begin
            w_err         = 1'b1;
            w_load_period = 1'b1;
            w_next        = ST_FAIL;
          end
        end
      end
      ST_POLL: begin
        if (!enable) w_next = ST_IDLE;
        else if (!phy_busy) begin
          w_start       = 1'b1;
          w_load_period = 1'b1;
          w_next        = ST_POLL_WAIT;
        end
      end
      ST_POLL_WAIT: begin
        if (w_finish) begin
          if (!enable) w_next = ST_IDLE;
          else if (phy_done) begin
            w_poll_ok = 1'b1;
            w_next    = ST_PERIOD;
          end else begin
            w_err         = 1'b1;
            w_retry_inc   = 1'b1;
            w_load_period = 1'b1;
            w_next        = ST_FAIL;
          end
        end
      end
      ST_PERIOD: begin
        if (!enable) w_next = ST_IDLE;
        else if (w_period_exp) w_next = ST_POLL;
      end
      ST_FAIL: begin
        if (!enable) w_next = ST_IDLE;
        else if (w_period_exp) begin
          if (w_retry_max) begin
            w_disconnect = 1'b1;
            w_next       = ST_PROBE;
          end else if (r_connected) begin
            w_next = ST_POLL;
          end else begin
            w_next = ST_PROBE;
          end
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Command/length are presented as soon as a launch state is entered, then held until the next launch.
  always_comb begin
    w_cmd = r_cmd;
    w_len = r_len;
    if (r_state == ST_POLL) begin
      w_cmd = CMD_POLL;
      w_len = RESP_LEN_POLL;
    end else if (r_state == ST_PROBE) begin
      w_cmd = CMD_STATUS;
      w_len = RESP_LEN_STATUS;
    end
  end

  // Datapath: latched command, results, link status, error and retry counters.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_cmd           <= CMD_STATUS;
      r_len           <= '0;
      r_buttons       <= '0;
      r_buttons_valid <= 1'b0;
      r_connected     <= 1'b0;
      r_ctrl_type     <= '0;
      r_err_count     <= '0;
      r_retry         <= '0;
    end else begin
      r_buttons_valid <= w_poll_ok;
      if (w_start) begin
        r_cmd <= w_cmd;
        r_len <= w_len;
      end
      if (w_probe_ok) begin
        r_ctrl_type <= phy_rx_data[31:16];
        r_connected <= 1'b1;
      end
      if (w_poll_ok) r_buttons <= phy_rx_data;
      if (w_err && (r_err_count != 8'hFF)) r_err_count <= r_err_count + 8'd1;
      if (w_probe_ok || w_poll_ok || w_disconnect) r_retry <= '0;
      else if (w_retry_inc && !w_retry_max) r_retry <= r_retry + RW'(1);
      if (w_disconnect) begin
        r_connected <= 1'b0;
        r_buttons   <= '0;
      end
    end
  end

  assign phy_start     = w_start;
  assign phy_cmd       = w_cmd;
  assign phy_rx_len    = w_len;
  assign buttons       = r_buttons;
  assign buttons_valid = r_buttons_valid;
  assign connected     = r_connected;
  assign ctrl_type     = r_ctrl_type;
  assign err_count     = r_err_count;
  assign state_mon     = r_state;

endmodule

// File: tb/tb_n64_poll_scheduler.sv
// tb/tb_n64_poll_scheduler.sv - scoreboard bench for the N64 poll scheduler
module tb_n64_poll_scheduler;

  logic        PCLK = 1'b0;
  logic        PRESETn, enable;
  logic        phy_start, phy_busy, phy_done;
  logic [7:0]  phy_cmd;
  logic [5:0]  phy_rx_len;
  logic [31:0] phy_rx_data, buttons;
  logic        buttons_valid, connected;
  logic [15:0] ctrl_type;
  logic [7:0]  err_count;
  logic [2:0]  state_mon;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [7:0] cmd;
    logic [5:0] len;
    int         gap;
  } start_t;

  start_t      exp_starts[$];
  logic [31:0] exp_buttons[$];
  int          n_starts   = 0;
  int          last_start = 0;
  int          n_done     = 0;
  int          last_done  = 0;
  logic        prev_bv    = 1'b0;

  logic        m_on    = 1'b0;
  int          m_delay = 40;
  logic [15:0] m_id    = 16'h0500;
  logic [31:0] m_poll  = 32'h0;
  logic        m_pend  = 1'b0;
  int          m_due   = 0;
  logic [31:0] m_data  = 32'h0;

  n64_poll_scheduler #(
    .TICKS_PER_MICRO (1),
    .POLL_PERIOD_US  (100),
    .TIMEOUT_US      (50),
    .MAX_RETRY       (3)
  ) dut (
    .PCLK          (PCLK),
    .PRESETn       (PRESETn),
    .enable        (enable),
    .phy_start     (phy_start),
    .phy_cmd       (phy_cmd),
    .phy_rx_len    (phy_rx_len),
    .phy_busy      (phy_busy),
    .phy_done      (phy_done),
    .phy_rx_data   (phy_rx_data),
    .buttons       (buttons),
    .buttons_valid (buttons_valid),
    .connected     (connected),
    .ctrl_type     (ctrl_type),
    .err_count     (err_count),
    .state_mon     (state_mon)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void push_start(input logic [7:0] c, input logic [5:0] l, input int g);
    start_t e;
    e.cmd = c;
    e.len = l;
    e.gap = g;
    exp_starts.push_back(e);
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge PCLK);
      #1;
    end
  endtask

  task automatic wait_starts(input int n, input int budget);
    int k = 0;
    while (n_starts < n && k < budget) begin
      tick(1);
      k++;
    end
    n_checks++;
    if (n_starts < n) begin
      n_fail++;
      $display("FAIL wait_starts: got %0d starts, required %0d", n_starts, n);
    end
  endtask

  // PHY model: answers m_delay cycles after each captured phy_start.
  initial begin
    phy_busy    = 1'b0;
    phy_done    = 1'b0;
    phy_rx_data = 32'h0;
    forever begin
      @(posedge PCLK);
      cyc++;
      #1;
      phy_done = 1'b0;
      if (m_pend && cyc == m_due) begin
        phy_done    = 1'b1;
        phy_rx_data = m_data;
        m_pend      = 1'b0;
      end
      phy_busy = m_pend;
    end
  end

  // Monitor: pops expected starts and button updates and compares them.
  always @(negedge PCLK) begin
    start_t e;
    logic [31:0] eb;
    if (!PRESETn) begin
      m_pend = 1'b0;
    end else if (phy_start) begin
      n_starts++;
      if (exp_starts.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL start_unexpected: got cmd %h, required no start", phy_cmd);
      end else begin
        e = exp_starts.pop_front();
        chk("start_cmd", {24'h0, phy_cmd}, {24'h0, e.cmd});
        chk("start_len", {26'h0, phy_rx_len}, {26'h0, e.len});
        if (e.gap != 0) chk("start_gap", 32'(cyc - last_start), 32'(e.gap));
      end
      last_start = cyc;
      if (m_on) begin
        m_pend = 1'b1;
        m_due  = cyc + m_delay;
        m_data = (phy_cmd == 8'h00) ? {m_id, 16'h0000} : m_poll;
      end
    end
    if (phy_done) begin
      n_done++;
      last_done = cyc;
    end
    if (buttons_valid) begin
      if (exp_buttons.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL bv_unexpected: got buttons %h, required no update", buttons);
      end else begin
        eb = exp_buttons.pop_front();
        chk("buttons", buttons, eb);
        chk("bv_latency", 32'(cyc - last_done), 32'd1);
      end
    end
    if (prev_bv) chk("bv_width", {31'h0, buttons_valid}, 32'h0);
    prev_bv = buttons_valid;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int k;
    PRESETn = 1'b0;
    enable  = 1'b0;
    tick(3);
    chk("rst_start",  {31'h0, phy_start}, 32'h0);
    chk("rst_cmd",    {24'h0, phy_cmd}, 32'h0);
    chk("rst_len",    {26'h0, phy_rx_len}, 32'h0);
    chk("rst_buttons", buttons, 32'h0);
    chk("rst_bv",     {31'h0, buttons_valid}, 32'h0);
    chk("rst_conn",   {31'h0, connected}, 32'h0);
    chk("rst_ctype",  {16'h0, ctrl_type}, 32'h0);
    chk("rst_err",    {24'h0, err_count}, 32'h0);
    chk("rst_state",  {29'h0, state_mon}, 32'h0);
    PRESETn = 1'b1;
    tick(2);

    // Probe with a good ID, then polls 100 cycles apart.
    m_on = 1'b1; m_delay = 40; m_id = 16'h0500; m_poll = 32'h8000_1234;
    push_start(8'h00, 6'd25, 0);
    push_start(8'h01, 6'd33, 41);
    push_start(8'h01, 6'd33, 100);
    push_start(8'h01, 6'd33, 100);
    repeat (3) exp_buttons.push_back(32'h8000_1234);
    enable = 1'b1;
    wait_starts(4, 400);
    chk("p1_conn",  {31'h0, connected}, 32'h1);
    chk("p1_ctype", {16'h0, ctrl_type}, 32'h0000_0500);
    chk("p1_err",   {24'h0, err_count}, 32'h0);
    tick(45);
    chk("p1_buttons", buttons, 32'h8000_1234);
    m_on = 1'b0;

    // Silent PHY: three POLL timeouts, then disconnect and re-probe.
    push_start(8'h01, 6'd33, 100);
    push_start(8'h01, 6'd33, 150);
    push_start(8'h01, 6'd33, 150);
    push_start(8'h00, 6'd25, 150);
    wait_starts(7, 600);
    tick(52);
    chk("p3_err3",  {24'h0, err_count}, 32'd3);
    chk("p3_conn1", {31'h0, connected}, 32'h1);
    wait_starts(8, 200);
    chk("p3_disc_conn",    {31'h0, connected}, 32'h0);
    chk("p3_disc_buttons", buttons, 32'h0);
    chk("p3_disc_err",     {24'h0, err_count}, 32'd3);

    // Wrong device ID answered on the timeout cycle: one error per probe.
    m_on = 1'b1; m_delay = 50; m_id = 16'h0001;
    push_start(8'h00, 6'd25, 150);
    push_start(8'h00, 6'd25, 150);
    wait_starts(10, 400);
    chk("p4_err",   {24'h0, err_count}, 32'd5);
    chk("p4_conn",  {31'h0, connected}, 32'h0);
    chk("p4_ctype", {16'h0, ctrl_type}, 32'h0000_0500);

    // Good ID and poll answered exactly on the timeout cycle count as success.
    m_id = 16'h0500; m_poll = 32'h0000_00FF;
    push_start(8'h00, 6'd25, 150);
    push_start(8'h01, 6'd33, 51);
    push_start(8'h01, 6'd33, 100);
    repeat (2) exp_buttons.push_back(32'h0000_00FF);
    wait_starts(13, 400);
    chk("p5_err",  {24'h0, err_count}, 32'd6);
    chk("p5_conn", {31'h0, connected}, 32'h1);

    // Enable dropped mid-POLL_WAIT: transaction finishes, result discarded.
    m_delay = 40; m_poll = 32'hDEAD_BEEF;
    push_start(8'h01, 6'd33, 100);
    wait_starts(14, 200);
    enable = 1'b0;
    tick(1);
    chk("p6_wait_state", {29'h0, state_mon}, 32'd5);
    d0 = n_done;
    k  = 0;
    while (n_done == d0 && k < 80) begin
      tick(1);
      k++;
    end
    chk("p6_done_seen", {31'h0, (n_done > d0)}, 32'h1);
    chk("p6_idle",      {29'h0, state_mon}, 32'd0);
    chk("p6_buttons",   buttons, 32'h0000_00FF);
    chk("p6_conn",      {31'h0, connected}, 32'h1);

    // Re-enable, then reset in the middle of a POLL transaction.
    push_start(8'h00, 6'd25, 42);
    push_start(8'h01, 6'd33, 41);
    enable = 1'b1;
    wait_starts(16, 200);
    tick(10);
    chk("p7_pre_state", {29'h0, state_mon}, 32'd5);
    PRESETn = 1'b0;
    #1;
    chk("p7_start",   {31'h0, phy_start}, 32'h0);
    chk("p7_cmd",     {24'h0, phy_cmd}, 32'h0);
    chk("p7_len",     {26'h0, phy_rx_len}, 32'h0);
    chk("p7_buttons", buttons, 32'h0);
    chk("p7_bv",      {31'h0, buttons_valid}, 32'h0);
    chk("p7_conn",    {31'h0, connected}, 32'h0);
    chk("p7_ctype",   {16'h0, ctrl_type}, 32'h0);
    chk("p7_err",     {24'h0, err_count}, 32'h0);
    chk("p7_state",   {29'h0, state_mon}, 32'h0);
    enable = 1'b0;
    m_on   = 1'b0;
    tick(60);
    PRESETn = 1'b1;
    tick(5);
    chk("starts_left",  32'(exp_starts.size()), 32'h0);
    chk("buttons_left", 32'(exp_buttons.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
